// File: rtl/octal_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Latency: none (definitions only).
// Backpressure: n/a.
package octal_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot_of(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/octal_rr_arbiter_rr_pick.sv
// Rotating-priority winner select: first set req bit scanning ptr, ptr+1, ... mod 8.
// Latency: purely combinational.
// Backpressure: none; caller decides when to consume the pick.
module rr_pick
    import octal_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] win_idx,
    output logic [N_REQ-1:0] win_oh
);

    logic [N_REQ-1:0] rot_req;
    logic [IDX_W-1:0] lo_idx;

    // Rotating right by ptr puts requester ptr at bit 0, so fixed LSB-first
    // priority on the rotated vector realises the round-robin order.
    assign rot_req = N_REQ'({req, req} >> ptr);

    always_comb begin
        lo_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                lo_idx = IDX_W'(i);
            end
        end
    end

    assign any     = |req;
    assign win_idx = lo_idx + ptr;
    assign win_oh  = any ? onehot_of(win_idx) : '0;

endmodule

// File: rtl/octal_rr_arbiter.sv
// Registered 8-way round-robin arbiter with sticky one-hot grant and binary index.
// Latency: req in cycle N -> gnt_valid in N+1; back-to-back grants at one per cycle.
// Backpressure: grant held until out_ready; pointer advances only on handshake.
module octal_rr_arbiter #(
    parameter int N_REQ     = 8,
    parameter int RESET_PTR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [2:0]       gnt_idx
);

    octal_arb_pkg::arb_state_e state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]       gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;

    logic             hshk;
    logic [2:0]       pick_ptr;
    logic             pick_any;
    logic [2:0]       pick_idx;
    logic [N_REQ-1:0] pick_oh;

    // On a handshake the next winner is chosen with the post-handshake pointer.
    assign hshk     = (state_q == octal_arb_pkg::HOLD) && out_ready;
    assign pick_ptr = hshk ? gnt_idx_q + 3'd1 : ptr_q;

    rr_pick u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .any     (pick_any),
        .win_idx (pick_idx),
        .win_oh  (pick_oh)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        case (state_q)
            octal_arb_pkg::IDLE: begin
                if (pick_any) begin
                    state_d     = octal_arb_pkg::HOLD;
                    gnt_d       = pick_oh;
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                end
            end
            octal_arb_pkg::HOLD: begin
                if (out_ready) begin
                    ptr_d = pick_ptr;
                    if (pick_any) begin
                        gnt_d     = pick_oh;
                        gnt_idx_d = pick_idx;
                    end else begin
                        state_d     = octal_arb_pkg::IDLE;
                        gnt_d       = '0;
                        gnt_idx_d   = '0;
                        gnt_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = octal_arb_pkg::IDLE;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= octal_arb_pkg::IDLE;
            ptr_q       <= 3'(RESET_PTR);
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_octal_rr_arbiter.sv
// Bench for octal_rr_arbiter: reference model feeds an expectation queue each cycle.
// Latency: expectations compared 1 time unit after the capturing edge.
// Backpressure: out_ready driven directly by the stimulus.
module tb_octal_rr_arbiter;

    typedef struct packed {
        logic [7:0] gnt;
        logic       vld;
        logic [2:0] idx;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;

    int total;
    int bad;

    exp_t exp_q[$];

    // Reference model state: mirrors what the DUT outputs should currently be.
    logic       m_vld;
    logic [2:0] m_ptr;
    logic [2:0] m_idx;

    octal_rr_arbiter #(
        .N_REQ     (8),
        .RESET_PTR (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_vld = 1'b0;
        m_ptr = 3'd0;
        m_idx = 3'd0;
    endtask

    function automatic logic [2:0] scan_win(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] j;
        logic       found;
        scan_win = 3'd0;
        found    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            j = p + 3'(k);
            if (!found && r[j]) begin
                scan_win = j;
                found    = 1'b1;
            end
        end
    endfunction

    task automatic model_step(input logic [7:0] r, input logic rdy);
        exp_t e;
        if (!m_vld) begin
            if (|r) begin
                m_idx = scan_win(r, m_ptr);
                m_vld = 1'b1;
            end
        end else if (rdy) begin
            m_ptr = m_idx + 3'd1;
            if (|r) begin
                m_idx = scan_win(r, m_ptr);
            end else begin
                m_vld = 1'b0;
                m_idx = 3'd0;
            end
        end
        e.vld = m_vld;
        e.idx = m_idx;
        e.gnt = m_vld ? (8'h01 << m_idx) : 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [7:0] r, input logic rdy);
        exp_t e;
        @(negedge clk);
        req       = r;
        out_ready = rdy;
        model_step(r, rdy);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("gnt_valid", 32'(gnt_valid), 32'(e.vld));
            chk("gnt_idx", 32'(gnt_idx), 32'(e.idx));
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        model_reset();

        #2;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_vld", 32'(gnt_valid), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            step(8'h00, 1'b0);
        end

        // Two requesters at opposite ends alternate every cycle.
        for (int k = 0; k < 6; k++) begin
            step(8'h81, 1'b1);
            chk("alt_idx", 32'(gnt_idx), (k % 2 == 0) ? 32'd0 : 32'd7);
            chk("alt_vld", 32'(gnt_valid), 32'd1);
        end
        step(8'h00, 1'b1);

        // All requesting: grant walks through every index and wraps.
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 1'b1);
            chk("ff_idx", 32'(gnt_idx), 32'(k % 8));
            chk("ff_gnt", 32'(gnt), 32'(8'h01 << (k % 8)));
        end
        step(8'h00, 1'b1);

        // Grant is sticky while the consumer stalls, even after req drops.
        step(8'h08, 1'b0);
        chk("hold_first", 32'(gnt), 32'h08);
        for (int k = 0; k < 4; k++) begin
            step(8'h00, 1'b0);
            chk("hold_sticky", 32'(gnt), 32'h08);
        end
        step(8'h00, 1'b1);
        chk("hold_clear", 32'(gnt), 32'h00);
        chk("hold_clear_vld", 32'(gnt_valid), 32'd0);

        // Sole requester is re-granted; with a competitor the served one yields.
        step(8'h20, 1'b0);
        chk("re5_first", 32'(gnt_idx), 32'd5);
        step(8'h20, 1'b1);
        chk("re5_sole", 32'(gnt_idx), 32'd5);
        chk("re5_vld", 32'(gnt_valid), 32'd1);
        step(8'h24, 1'b1);
        chk("re5_yield", 32'(gnt_idx), 32'd2);
        step(8'h00, 1'b1);

        // Asynchronous reset mid-HOLD.
        step(8'h10, 1'b0);
        chk("pre_rst_gnt", 32'(gnt), 32'h10);
        @(negedge clk);
        req = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_vld", 32'(gnt_valid), 32'd0);
        chk("async_idx", 32'(gnt_idx), 32'd0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(8'hFF, 1'b0);
        chk("post_rst_idx", 32'(gnt_idx), 32'd0);
        chk("post_rst_vld", 32'(gnt_valid), 32'd1);

        // Random traffic against the model.
        for (int k = 0; k < 200; k++) begin
            step(8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
